// File: rtl/prog_frac_freq_div.sv
// Runtime-programmable fractional clock divider.
// Ratio changes land on CLK_out low-phase boundaries; equal ratios gate CLK_in directly.
module prog_frac_freq_div #(
  parameter int W           = 8,
  parameter int DEF_DIV_IN  = 3,
  parameter int DEF_DIV_OUT = 1
) (
  input  logic         CLK_in,
  input  logic         RST,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div_in,
  input  logic [W-1:0] cfg_div_out,
  output logic         CLK_out,
  output logic         tick,
  output logic         cfg_err,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BYPASS = 2'd2
  } state_t;

  localparam logic [W-1:0] RST_IN  = W'(DEF_DIV_IN);
  localparam logic [W-1:0] RST_OUT = W'(DEF_DIV_OUT);

  state_t       state, state_d;
  logic [W:0]   acc, acc_d;
  logic         clk_q, clk_d;
  logic         tick_d, err_d;
  logic [W-1:0] act_in, act_in_d;
  logic [W-1:0] act_out, act_out_d;
  logic         pend_v, pend_v_d;
  logic [W-1:0] pend_in, pend_in_d;
  logic [W-1:0] pend_out, pend_out_d;
  logic         byp_q;

  logic         xfer, legal, tog, leave;
  logic [W+1:0] sum;

  assign cfg_ready = !pend_v;
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_div_out != '0) &&
                     ((cfg_div_in == cfg_div_out) ||
                      ({1'b0, cfg_div_in} >= {cfg_div_out, 1'b0}));
  assign sum       = {1'b0, acc} + {1'b0, act_out, 1'b0};
  assign tog       = sum >= {2'b00, act_in};
  assign busy      = state != IDLE;
  assign CLK_out   = clk_q | (CLK_in & byp_q);

  always_comb begin
    state_d    = state;
    acc_d      = acc;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    err_d      = xfer && !legal;
    act_in_d   = act_in;
    act_out_d  = act_out;
    pend_v_d   = pend_v;
    pend_in_d  = pend_in;
    pend_out_d = pend_out;
    leave      = 1'b0;
    if (xfer && legal && state != IDLE) begin
      pend_v_d   = 1'b1;
      pend_in_d  = cfg_div_in;
      pend_out_d = cfg_div_out;
    end
    unique case (state)
      IDLE: begin
        acc_d = '0;
        clk_d = 1'b0;
        if (xfer && legal) begin
          act_in_d  = cfg_div_in;
          act_out_d = cfg_div_out;
        end else if (pend_v) begin
          act_in_d  = pend_in;
          act_out_d = pend_out;
          pend_v_d  = 1'b0;
        end
        if (en)
          state_d = (act_in_d == act_out_d) ? BYPASS : RUN;
      end
      RUN: begin
        // boundary: falling toggle, or already low with no toggle due
        if ((tog == clk_q) && (pend_v || !en)) begin
          leave = 1'b1;
        end else begin
          acc_d  = tog ? W'(sum - {2'b00, act_in}) : sum[W:0];
          clk_d  = clk_q ^ tog;
          tick_d = tog && !clk_q;
        end
      end
      BYPASS: begin
        acc_d = '0;
        clk_d = 1'b0;
        if ((pend_v || !en) && !byp_q)
          leave = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (leave) begin
      acc_d = '0;
      clk_d = 1'b0;
      if (pend_v) begin
        act_in_d  = pend_in;
        act_out_d = pend_out;
        pend_v_d  = 1'b0;
      end
      if (!en)
        state_d = IDLE;
      else
        state_d = (act_in_d == act_out_d) ? BYPASS : RUN;
    end
  end

  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      acc      <= '0;
      clk_q    <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
      act_in   <= RST_IN;
      act_out  <= RST_OUT;
      pend_v   <= 1'b0;
      pend_in  <= '0;
      pend_out <= '0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      clk_q    <= clk_d;
      tick     <= tick_d;
      cfg_err  <= err_d;
      act_in   <= act_in_d;
      act_out  <= act_out_d;
      pend_v   <= pend_v_d;
      pend_in  <= pend_in_d;
      pend_out <= pend_out_d;
    end
  end

  // gate enable only moves while CLK_in is low
  always_ff @(negedge CLK_in or negedge RST) begin
    if (!RST)
      byp_q <= 1'b0;
    else
      byp_q <= (state == BYPASS) && en && !pend_v;
  end

endmodule
